// File: rtl/bit_serial_adder_sched_if.sv
// Bundle between the round-robin scheduler, its requesters, the shared
// bit-serial adder lane and the result consumer.
interface bit_serial_adder_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_sign;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     adder_reset;
  logic                     adder_in;
  logic                     adder_sign;
  logic                     adder_out;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_ready;
  logic                     busy;

  // Environment side: requesters, adder lane and result consumer.
  modport master (
    output req_valid, req_data, req_sign, adder_out, out_ready,
    input  req_ready, adder_reset, adder_in, adder_sign,
           out_valid, out_data, out_id, busy
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, req_sign, adder_out, out_ready,
    output req_ready, adder_reset, adder_in, adder_sign,
           out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/bit_serial_adder_sched.sv
// Round-robin scheduler sharing one bit-serial adder lane between requesters.
// A granted operand is streamed LSB-first into a freshly cleared adder and the
// registered serial result is deserialized and returned tagged with its owner.
//
// state  | meaning
// IDLE   | adder held cleared; grant one requester, latch its job
// CLEAR  | one cycle of adder reset with the job's sign already applied
// STREAM | WIDTH cycles feeding operand bits; result bits trail by one cycle
// DRAIN  | collect the last result bit from the adder's output register
// DONE   | result presented until the consumer accepts it
module bit_serial_adder_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input logic                    clk,
  input logic                    reset_n,
  bit_serial_adder_sched_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [WIDTH-1:0]   r_op;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_bit_cnt;
  // Only WIDTH-1 bits are collected here; the final bit goes straight into
  // the output register on the DRAIN cycle.
  logic [WIDTH-2:0]   r_res;
  logic               r_adder_reset;
  logic               r_adder_in;
  logic               r_adder_sign;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [ID_W-1:0]    r_out_id;
  logic               r_busy;

  logic               w_found;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_next_ptr;
  logic [NUM_REQ-1:0] w_gnt_oh;
  int                 w_idx;

  // Rotating priority search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_gnt_oh = '0;
    w_idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = ID_W'(w_idx);
      end
    end
    if (w_found) w_gnt_oh[w_gnt_id] = 1'b1;
  end

  assign w_next_ptr = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

  // Accept pulse is combinational so the requester sees it in the grant cycle;
  // gating with reset_n keeps it quiet while reset is asserted.
  assign bus.req_ready   = (r_state == S_IDLE && reset_n) ? w_gnt_oh : '0;
  assign bus.adder_reset = r_adder_reset;
  assign bus.adder_in    = r_adder_in;
  assign bus.adder_sign  = r_adder_sign;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_id      = r_out_id;
  assign bus.busy        = r_busy;

  // Job sequencer with registered adder controls and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_op          <= '0;
      r_id          <= '0;
      r_bit_cnt     <= '0;
      r_res         <= '0;
      r_adder_reset <= 1'b1;
      r_adder_in    <= 1'b0;
      r_adder_sign  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_id      <= '0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op         <= bus.req_data[int'(w_gnt_id)*WIDTH +: WIDTH];
            r_adder_sign <= bus.req_sign[w_gnt_id];
            r_id         <= w_gnt_id;
            r_rr_ptr     <= w_next_ptr;
            r_busy       <= 1'b1;
            r_state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_bit_cnt     <= CNT_W'(WIDTH - 1);
          r_adder_reset <= 1'b0;
          r_adder_in    <= r_op[0];
          r_op          <= r_op >> 1;
          r_state       <= S_STREAM;
        end
        S_STREAM: begin
          // First stream cycle has nothing valid at the adder output yet.
          if (r_bit_cnt != CNT_W'(WIDTH - 1)) begin
            r_res <= {bus.adder_out, r_res[WIDTH-2:1]};
          end
          if (r_bit_cnt == '0) begin
            r_adder_in   <= 1'b0;
            r_adder_sign <= 1'b0;
            r_state      <= S_DRAIN;
          end else begin
            r_adder_in <= r_op[0];
            r_op       <= r_op >> 1;
            r_bit_cnt  <= r_bit_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          r_out_data    <= {bus.adder_out, r_res};
          r_out_id      <= r_id;
          r_out_valid   <= 1'b1;
          r_adder_reset <= 1'b1;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_adder_sched.sv
module tb_bit_serial_adder_sched;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int ID_W    = 2;

  logic clk;
  logic reset_n;
  logic real_mode;
  logic stub_q;
  logic real_q;
  logic real_c;
  int   cyc;
  int   n_checks;
  int   n_fail;

  bit_serial_adder_sched_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  bit_serial_adder_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Adder lane models: a pass-through register and a serial adder that adds
  // the (optionally inverted) stream to zero with carry-in = sign, i.e. +x / -x.
  always @(posedge clk) begin
    stub_q <= bus.adder_in;
    if (bus.adder_reset) begin
      real_q <= 1'b0;
      real_c <= bus.adder_sign;
    end else begin
      real_q <= (bus.adder_in ^ bus.adder_sign) ^ real_c;
      real_c <= (bus.adder_in ^ bus.adder_sign) & real_c;
    end
  end
  assign bus.adder_out = real_mode ? real_q : stub_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for an accept pulse, then steps past the accept edge.
  task automatic wait_accept(input string tag, input bit drop, output int g);
    int n;
    g = -1;
    for (n = 0; n < 300; n++) begin
      @(negedge clk); #1;
      if (bus.req_ready != '0) break;
    end
    if (n == 300) begin
      chk({tag, "_accept_timeout"}, 64'(bus.req_ready), 64'd1);
    end else begin
      chk({tag, "_onehot"}, 64'($countones(bus.req_ready)), 64'd1);
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) g = i;
    end
    @(posedge clk); #1;
    if (drop && g >= 0) bus.req_valid[g] = 1'b0;
  endtask

  // Follows one job from the CLEAR cycle to the result handshake.
  task automatic run_job(input string tag, input logic [31:0] op, input logic [31:0] exp_res,
                         input int exp_id, input logic exp_sign, input int hold);
    logic [31:0] bits;
    int rst_low, sign_ok, ov_early, rr_any, busy_lo, in_stray, unstable;
    bits = '0; rst_low = 0; sign_ok = 0; ov_early = 0; rr_any = 0; busy_lo = 0; in_stray = 0;
    for (int j = 0; j <= 33; j++) begin
      @(negedge clk); #1;
      if (j >= 1 && j <= 32) bits[j-1] = bus.adder_in;
      else if (bus.adder_in) in_stray++;
      if (!bus.adder_reset) rst_low++;
      if (j <= 32 && bus.adder_sign == exp_sign) sign_ok++;
      if (bus.out_valid) ov_early++;
      if (bus.req_ready != '0) rr_any++;
      if (!bus.busy) busy_lo++;
    end
    chk({tag, "_stream"}, 64'(bits), 64'(op));
    chk({tag, "_in_stray"}, 64'(in_stray), 64'd0);
    chk({tag, "_rst_low"}, 64'(rst_low), 64'd33);
    chk({tag, "_sign"}, 64'(sign_ok), 64'd33);
    chk({tag, "_ov_early"}, 64'(ov_early), 64'd0);
    chk({tag, "_ready_busy"}, 64'(rr_any), 64'd0);
    chk({tag, "_busy"}, 64'(busy_lo), 64'd0);
    @(negedge clk); #1;
    chk({tag, "_ov"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_data"}, 64'(bus.out_data), 64'(exp_res));
    chk({tag, "_id"}, 64'(bus.out_id), 64'(exp_id));
    chk({tag, "_done_rst"}, 64'(bus.adder_reset), 64'd1);
    if (hold > 0) begin
      unstable = 0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk); #1;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_res || bus.out_id !== ID_W'(exp_id) ||
            bus.req_ready !== '0 || bus.adder_reset !== 1'b1) unstable++;
      end
      chk({tag, "_hold"}, 64'(unstable), 64'd0);
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] d [NUM_REQ];
  logic [31:0] d1;
  int g;
  int t_acc [5];
  int exp_order [5];

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    real_mode = 1'b0;
    d[0] = 32'hA5A5_0F0F; d[1] = 32'h1234_5678; d[2] = 32'hDEAD_BEEF; d[3] = 32'h0000_0001;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    bus.req_valid = 4'b1111;
    bus.req_sign  = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = d[i];
    reset_n = 1'b0;

    // Reset values with requests pending.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_adder_reset", 64'(bus.adder_reset), 64'd1);
    chk("rst_adder_in", 64'(bus.adder_in), 64'd0);
    chk("rst_adder_sign", 64'(bus.adder_sign), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_id", 64'(bus.out_id), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    reset_n = 1'b1;

    // Single job from requester 0 through the pass-through lane.
    bus.req_valid = 4'b0001;
    wait_accept("t1", 1'b1, g);
    chk("t1_gnt", 64'(g), 64'd0);
    run_job("t1", d[0], d[0], 0, 1'b0, 0);

    // Fresh pointer, all requests held: strict rotation at WIDTH+4 spacing.
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_accept("t2", 1'b0, g);
      t_acc[n] = cyc;
      chk("t2_order", 64'(g), 64'(exp_order[n]));
      if (n > 0) chk("t2_period", 64'(t_acc[n] - t_acc[n-1]), 64'd36);
      if (n == 4) bus.req_valid = '0;
      if (g >= 0) run_job("t2", d[g], d[g], g, 1'b0, 0);
    end

    // Pointer past requester 1: requester 0 wins over 1, then 1 follows.
    bus.req_valid = 4'b0010;
    wait_accept("t3a", 1'b1, g);
    chk("t3a_gnt", 64'(g), 64'd1);
    run_job("t3a", d[1], d[1], 1, 1'b0, 0);
    bus.req_valid = 4'b0011;
    wait_accept("t3b", 1'b1, g);
    chk("t3b_gnt", 64'(g), 64'd0);
    run_job("t3b", d[0], d[0], 0, 1'b0, 0);
    wait_accept("t3c", 1'b1, g);
    chk("t3c_gnt", 64'(g), 64'd1);
    run_job("t3c", d[1], d[1], 1, 1'b0, 0);

    // Consumer stalls 10 cycles with another request waiting.
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0101;
    wait_accept("t4a", 1'b1, g);
    chk("t4a_gnt", 64'(g), 64'd2);
    run_job("t4a", d[2], d[2], 2, 1'b0, 10);
    wait_accept("t4b", 1'b1, g);
    chk("t4b_gnt", 64'(g), 64'd0);
    run_job("t4b", d[0], d[0], 0, 1'b0, 0);

    // Reset while bit 12 is on the lane; the held request is re-granted.
    d1 = d[1];
    bus.req_valid = 4'b0010;
    wait_accept("t5", 1'b0, g);
    chk("t5_gnt", 64'(g), 64'd1);
    for (int j = 0; j <= 13; j++) begin
      @(negedge clk); #1;
    end
    chk("t5_bit12", 64'(bus.adder_in), 64'(d1[12]));
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("t5_rst_adder_reset", 64'(bus.adder_reset), 64'd1);
    chk("t5_rst_adder_in", 64'(bus.adder_in), 64'd0);
    chk("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_rst_out_data", 64'(bus.out_data), 64'd0);
    chk("t5_rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_accept("t5r", 1'b1, g);
    chk("t5r_gnt", 64'(g), 64'd1);
    run_job("t5r", d[1], d[1], 1, 1'b0, 0);

    // Serial adder lane: -0 (carry out discarded), -5, +7.
    real_mode = 1'b1;
    bus.req_data[0*WIDTH +: WIDTH] = 32'h0000_0000;
    bus.req_sign = 4'b0001;
    bus.req_valid = 4'b0001;
    wait_accept("t6a", 1'b1, g);
    chk("t6a_gnt", 64'(g), 64'd0);
    run_job("t6a", 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 0);
    bus.req_data[0*WIDTH +: WIDTH] = 32'h0000_0005;
    bus.req_valid = 4'b0001;
    wait_accept("t6b", 1'b1, g);
    chk("t6b_gnt", 64'(g), 64'd0);
    run_job("t6b", 32'h0000_0005, 32'hFFFF_FFFB, 0, 1'b1, 0);
    bus.req_data[3*WIDTH +: WIDTH] = 32'h0000_0007;
    bus.req_sign = 4'b0000;
    bus.req_valid = 4'b1000;
    wait_accept("t6c", 1'b1, g);
    chk("t6c_gnt", 64'(g), 64'd3);
    run_job("t6c", 32'h0000_0007, 32'h0000_0007, 3, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_serial_adder_sched.md
Name: bit_serial_adder_sched

Overview:
Round-robin scheduler that shares one bit-serial adder lane between NUM_REQ requesters.
- Accepts a parallel operand and sign select from the winning requester.
- Clears the adder, streams the operand LSB-first, and deserializes the adder's serial result.
- Returns the parallel result tagged with the requester id.
- Sits between the term-quantization accumulation front-end and the bit-serial adder instance.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 32, bits per operand/result word; matches the adder's 5-bit cycle counter period
ID_W, 2, requester id width (clog2(NUM_REQ))

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  reset; one clock; reset is asynchronous and active-low
req_valid  in  NUM_REQ  per-requester job request
req_data  in  NUM_REQ*WIDTH  operands; requester i at bits [i*WIDTH +: WIDTH]
req_sign  in  NUM_REQ  per-requester sign select
req_ready  out  NUM_REQ  one-hot accept pulse
adder_reset  out  1  drives adder reset (active-high)
adder_in  out  1  drives adder input_stream
adder_sign  out  1  drives adder sign_ctrl
adder_out  in  1  adder adder_results (registered; reflects the bit presented one cycle earlier)
out_valid  out  1  result available
out_data  out  WIDTH  deserialized result
out_id  out  ID_W  requester that owns out_data
out_ready  in  1  consumer accepts result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0.
  - Output values during reset: req_ready=0, adder_reset=1, adder_in=0, adder_sign=0, out_valid=0, out_data=0, out_id=0, busy=0.
  - Reset mid-job abandons the job with no output.
- FSM states: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - adder_reset=1.
  - If any req_valid: grant the first set bit searching from rr_ptr upward with wrap.
  - req_ready[g]=1 combinationally in that cycle.
  - Latch req_data[g], req_sign[g], and g; set rr_ptr=(g+1) mod NUM_REQ.
  - Go to CLEAR.
  - No valid: stay, rr_ptr unchanged.
- CLEAR:
  - 1 cycle, adder_reset=1, adder_sign=latched sign. Go to STREAM; bit counter=0.
- STREAM:
  - WIDTH cycles, adder_reset=0, adder_sign=latched sign.
  - In cycle k, adder_in=operand bit k.
  - In cycles k>=1, capture adder_out as result bit k-1 (shift into MSB, shift right).
  - After cycle WIDTH-1, go to DRAIN.
- DRAIN:
  - 1 cycle, adder_reset=0, adder_in=0.
  - Capture adder_out as result bit WIDTH-1.
  - Go to DONE.
- DONE:
  - out_valid=1; out_data and out_id held stable until out_ready.
  - out_valid&out_ready -> IDLE.
  - adder_reset=1 (adder held cleared).
- Outputs outside their defined states:
  - adder_in=0 outside STREAM.
  - req_ready=0 outside IDLE.
  - out_data keeps its last value after handshake.
- Latency and throughput:
  - out_valid first high WIDTH+2 cycles after the accept cycle.
  - Back-to-back minimum period WIDTH+4 cycles with out_ready tied high.
- Arbitration:
  - Requests dropped before grant are simply not seen.
  - Requests are not queued.
  - A requester holds req_valid and data until its req_ready pulse.
- Simultaneous requests: exactly one grant per IDLE cycle; no requester is starved longer than NUM_REQ-1 jobs.
- Width rule: result is exactly WIDTH bits. Carry out of the MSB is discarded; the adder is cleared per job, so no carry crosses jobs.

Test Plan:
- Adder stub (pass-through register), req_valid=4'b0001, req_data[0]=32'hA5A5_0F0F -> req_ready=4'b0001 for 1 cycle; adder_in shows 1,1,1,1,0,0,0,0... LSB-first; out_valid 34 cycles after accept with out_data=32'hA5A5_0F0F, out_id=0.
- All four req_valid held high, out_ready=1 -> grant order 0,1,2,3,0; accepts spaced 36 cycles apart.
- rr_ptr=2 (after a grant to 1), req_valid=4'b0011 -> grant to 0, not 1; next grant to 1.
- out_ready low 10 cycles in DONE -> out_valid, out_data, out_id stable; no new req_ready; adder_reset=1 throughout.
- reset_n pulsed low mid-STREAM (bit 12) -> all outputs immediately take reset values; after release, same request is re-granted and completes correctly.
- Real adder, req_sign=1, operand 0 -> adder_sign=1 for CLEAR+STREAM; adder_reset low for exactly 32+1 cycles; out_data matches the bench adder reference model.
